// File: rtl/irq_ctrl_pkg.sv
// Shared bus-offset and CP0 interrupt-FSM definitions for the interrupt controller.
package irq_ctrl_pkg;

  localparam logic [1:0] OFF_PEND = 2'd0;
  localparam logic [1:0] OFF_MASK = 2'd1;
  localparam logic [1:0] OFF_MODE = 2'd2;
  localparam logic [1:0] OFF_ISR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder; o_valid flags that any request is set.
module prio_enc #(
  parameter int NSRC = 6,
  parameter int IDW  = 3
) (
  input  logic [NSRC-1:0] i_req,
  output logic [IDW-1:0]  o_id,
  output logic            o_valid
);

  // NOTE: o_id gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    o_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (i_req[i]) o_id = IDW'(i);
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: per-source pending/mask/mode, fixed priority, CP0 req/ack/EOI handshake.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC = 6,
  parameter int IDW  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:2]     Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  input  logic [NSRC-1:0] irq_in,
  input  logic            int_ack,
  output logic            int_req,
  output logic [IDW-1:0]  int_id,
  output logic            in_svc
);

  irq_state_t      r_state;
  logic [NSRC-1:0] r_pend, r_mask, r_mode, r_irq_d;
  logic            r_int_req, r_in_svc;
  logic [IDW-1:0]  r_int_id;

  logic [NSRC-1:0] w_cand, w_edge, w_w1c, w_ack_clr, w_id_oh, w_edge_nxt, w_pend_nxt;
  logic            w_wr_pend, w_wr_mask, w_wr_mode, w_wr_isr;
  logic [IDW-1:0]  w_sel_id;
  logic            w_sel_valid;
  logic [2:0]      w_id3;
  logic            w_unused;

  assign w_wr_pend = WE && (Addr[3:2] == OFF_PEND);
  assign w_wr_mask = WE && (Addr[3:2] == OFF_MASK);
  assign w_wr_mode = WE && (Addr[3:2] == OFF_MODE);
  assign w_wr_isr  = WE && (Addr[3:2] == OFF_ISR);

  assign w_cand  = r_pend & r_mask;
  assign w_id_oh = {{(NSRC-1){1'b0}}, 1'b1} << r_int_id;

  // Edge sources: a fresh edge beats both the W1C write and the ack clear.
  assign w_edge     = irq_in & ~r_irq_d;
  assign w_w1c      = w_wr_pend ? Din[NSRC-1:0] : '0;
  assign w_ack_clr  = (r_state == REQ && int_ack) ? w_id_oh : '0;
  assign w_edge_nxt = w_edge | (r_pend & ~(w_w1c | w_ack_clr));
  assign w_pend_nxt = (r_mode & w_edge_nxt) | (~r_mode & irq_in);

  prio_enc #(.NSRC(NSRC), .IDW(IDW)) u_prio_enc (
    .i_req   (w_cand),
    .o_id    (w_sel_id),
    .o_valid (w_sel_valid)
  );

  // NOTE: all state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pend    <= '0;
      r_mask    <= '0;
      r_mode    <= '0;
      r_irq_d   <= '0;
      r_int_req <= 1'b0;
      r_in_svc  <= 1'b0;
      r_int_id  <= '0;
    end else begin
      r_irq_d <= irq_in;
      r_pend  <= w_pend_nxt;
      if (w_wr_mask) r_mask <= Din[NSRC-1:0];
      if (w_wr_mode) r_mode <= Din[NSRC-1:0];

      case (r_state)
        IDLE: begin
          if (w_sel_valid) begin
            r_state   <= REQ;
            r_int_id  <= w_sel_id;
            r_int_req <= 1'b1;
          end
        end
        REQ: begin
          if (int_ack) begin
            r_state   <= SERVICE;
            r_int_req <= 1'b0;
            r_in_svc  <= 1'b1;
          end else if ((w_cand & w_id_oh) == '0) begin
            r_state   <= IDLE;
            r_int_req <= 1'b0;
          end
        end
        SERVICE: begin
          if (w_wr_isr) begin
            r_state  <= IDLE;
            r_in_svc <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_int_req <= 1'b0;
          r_in_svc  <= 1'b0;
        end
      endcase
    end
  end

  assign w_id3 = 3'(r_int_id);

  always_comb begin
    Dout = '0;
    case (Addr[3:2])
      OFF_PEND: Dout = {{(32-NSRC){1'b0}}, r_pend};
      OFF_MASK: Dout = {{(32-NSRC){1'b0}}, r_mask};
      OFF_MODE: Dout = {{(32-NSRC){1'b0}}, r_mode};
      OFF_ISR:  Dout = {r_in_svc, 28'b0, w_id3};
      default:  Dout = '0;
    endcase
  end

  assign int_req  = r_int_req;
  assign int_id   = r_int_id;
  assign in_svc   = r_in_svc;
  assign w_unused = ^{Addr[31:4], Din[31:NSRC]};

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl: reset, edge/level sources, handshake, W1C races, reset in service.
module tb_irq_ctrl;

  localparam int NSRC = 6;
  localparam int IDW  = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [31:2]     addr;
  logic            we;
  logic [31:0]     din;
  logic [31:0]     dout;
  logic [NSRC-1:0] irq_in;
  logic            int_ack;
  logic            int_req;
  logic [IDW-1:0]  int_id;
  logic            in_svc;

  int n_cmp  = 0;
  int n_fail = 0;

  irq_ctrl #(.NSRC(NSRC), .IDW(IDW)) dut (
    .clk     (clk),
    .reset   (reset),
    .Addr    (addr),
    .WE      (we),
    .Din     (din),
    .Dout    (dout),
    .irq_in  (irq_in),
    .int_ack (int_ack),
    .int_req (int_req),
    .int_id  (int_id),
    .in_svc  (in_svc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] off, input logic [31:0] data);
    addr = {28'b0, off};
    din  = data;
    we   = 1'b1;
    tick();
    we   = 1'b0;
  endtask

  task automatic reg_read(input string tag, input logic [1:0] off, input logic [31:0] exp);
    addr = {28'b0, off};
    #1;
    check(tag, dout, exp);
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; addr = '0; we = 1'b0; din = '0; irq_in = '0; int_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    reg_read("rst_pend", 2'd0, 32'h0);
    reg_read("rst_mask", 2'd1, 32'h0);
    reg_read("rst_mode", 2'd2, 32'h0);
    reg_read("rst_isr",  2'd3, 32'h0);
    check("rst_int_req", 32'(int_req), 32'h0);
    check("rst_in_svc",  32'(in_svc),  32'h0);

    // Edge source 0: one-cycle pulse, full handshake
    reg_write(2'd1, 32'hFFFF_FFFF);
    reg_write(2'd2, 32'h0000_0001);
    reg_read("mask_rb", 2'd1, 32'h3F);
    reg_read("mode_rb", 2'd2, 32'h01);
    irq_in = 6'h01;
    tick();
    irq_in = 6'h00;
    reg_read("e0_pend", 2'd0, 32'h01);
    check("e0_req_lat1", 32'(int_req), 32'h0);
    tick();
    check("e0_req_lat2", 32'(int_req), 32'h1);
    check("e0_id", 32'(int_id), 32'h0);
    ack_pulse();
    check("e0_ack_req", 32'(int_req), 32'h0);
    check("e0_ack_svc", 32'(in_svc),  32'h1);
    reg_read("e0_ack_pend", 2'd0, 32'h00);
    reg_read("e0_isr", 2'd3, 32'h8000_0000);
    reg_write(2'd3, 32'h0);
    check("e0_eoi_svc", 32'(in_svc), 32'h0);

    // Level sources 2 and 5 held
    reg_write(2'd2, 32'h0);
    irq_in = 6'h24;
    tick(); tick();
    check("lv_req", 32'(int_req), 32'h1);
    check("lv_id2", 32'(int_id),  32'h2);
    ack_pulse();
    check("lv_svc", 32'(in_svc), 32'h1);
    reg_read("lv_isr", 2'd3, 32'h8000_0002);
    reg_read("lv_pend_kept", 2'd0, 32'h24);
    reg_write(2'd3, 32'h0);
    check("lv_eoi_svc", 32'(in_svc), 32'h0);
    tick();
    check("lv_rereq", 32'(int_req), 32'h1);
    check("lv_reid2", 32'(int_id),  32'h2);
    irq_in = 6'h20;
    tick();
    check("lv_drop_hold", 32'(int_req), 32'h1);
    tick();
    check("lv_drop_idle", 32'(int_req), 32'h0);
    tick();
    check("lv_req5", 32'(int_req), 32'h1);
    check("lv_id5",  32'(int_id),  32'h5);
    irq_in = 6'h00;
    ack_pulse();
    reg_write(2'd3, 32'h0);
    tick();
    check("lv_clean", 32'(int_req), 32'h0);

    // Level source 3 withdrawn before ack; later ack ignored
    irq_in = 6'h08;
    tick(); tick();
    check("wd_req", 32'(int_req), 32'h1);
    check("wd_id3", 32'(int_id),  32'h3);
    irq_in = 6'h00;
    tick(); tick();
    check("wd_idle", 32'(int_req), 32'h0);
    ack_pulse();
    check("wd_ack_svc", 32'(in_svc),  32'h0);
    check("wd_ack_req", 32'(int_req), 32'h0);
    reg_write(2'd3, 32'h0);
    check("wd_isr_ign", 32'(in_svc), 32'h0);

    // Edge source 1: W1C versus coincident edge, then plain W1C
    reg_write(2'd1, 32'h0);
    reg_write(2'd2, 32'h0000_0002);
    irq_in = 6'h02;
    tick();
    irq_in = 6'h00;
    reg_read("w1_pend_set", 2'd0, 32'h02);
    tick();
    irq_in = 6'h02;
    reg_write(2'd0, 32'h0000_0002);
    reg_read("w1_set_wins", 2'd0, 32'h02);
    reg_write(2'd0, 32'h0000_0002);
    reg_read("w1_cleared", 2'd0, 32'h00);

    // Reset while in SERVICE with level sources 4 and 5 pending
    irq_in = 6'h30;
    reg_write(2'd2, 32'h0);
    reg_write(2'd1, 32'h3F);
    tick();
    check("rs_id4", 32'(int_id), 32'h4);
    ack_pulse();
    check("rs_svc", 32'(in_svc), 32'h1);
    reg_read("rs_pend", 2'd0, 32'h30);
    reset = 1'b1;
    tick();
    reg_read("rs_pend0", 2'd0, 32'h0);
    reg_read("rs_mask0", 2'd1, 32'h0);
    reg_read("rs_mode0", 2'd2, 32'h0);
    reg_read("rs_isr0",  2'd3, 32'h0);
    check("rs_req0", 32'(int_req), 32'h0);
    check("rs_svc0", 32'(in_svc),  32'h0);
    reset = 1'b0;
    irq_in = 6'h00;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
